// File: rtl/demux_pkg.sv
// Shared constants and select decode for the 1-to-5 sample distributor.
package demux_pkg;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = SEL_W;

    // Out-of-range selects fall back here, matching the 5-to-1 mux default arm.
    localparam logic [CH_W-1:0] CH_DEFAULT = '0;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            misroute;
    } sel_map_t;

    // Map a raw select to a channel index; selects beyond the last channel are misroutes.
    function automatic sel_map_t map_sel(input logic [SEL_W-1:0] sel);
        sel_map_t m;
        if (int'(sel) < NUM_CH) begin
            m.ch       = sel;
            m.misroute = 1'b0;
        end else begin
            m.ch       = CH_DEFAULT;
            m.misroute = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry holding register with a valid/ready drain side.
module demux_ch_slot
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A write wins over a drain so a same-cycle drain+write keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot state; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux1to5_dist.sv
// 1-to-5 distributor: routes each accepted word into its channel's holding slot
// and counts words whose select is out of range.
module demux1to5_dist
    import demux_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [CNT_W-1:0]         misroute_cnt,
    output logic                     misroute_pulse
);

    sel_map_t          sel_map;
    logic              accept;
    logic [NUM_CH-1:0] wr_en;

    logic [CNT_W-1:0]  misroute_cnt_q, misroute_cnt_d;
    logic              misroute_pulse_q, misroute_pulse_d;

    // Decode destination and derive readiness from that channel alone.
    always_comb begin
        sel_map  = map_sel(in_sel);
        in_ready = !out_valid[sel_map.ch] || out_ready[sel_map.ch];
        accept   = in_valid && in_ready;
        wr_en    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept && (sel_map.ch == k[CH_W-1:0])) begin
                wr_en[k] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            demux_ch_slot u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_en[g]),
                .wr_data  (in_data),
                .rd_ready (out_ready[g]),
                .valid    (out_valid[g]),
                .data     (out_data[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Next misroute count saturates at all-ones; pulse marks every misrouted accept.
    always_comb begin
        misroute_pulse_d = accept && sel_map.misroute;
        misroute_cnt_d   = misroute_cnt_q;
        if (misroute_pulse_d && (misroute_cnt_q != {CNT_W{1'b1}})) begin
            misroute_cnt_d = misroute_cnt_q + 1'b1;
        end
    end

    // Misroute bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misroute_cnt_q   <= '0;
            misroute_pulse_q <= 1'b0;
        end else begin
            misroute_cnt_q   <= misroute_cnt_d;
            misroute_pulse_q <= misroute_pulse_d;
        end
    end

    assign misroute_cnt   = misroute_cnt_q;
    assign misroute_pulse = misroute_pulse_q;

endmodule

// File: tb/tb_demux1to5_dist.sv
// Directed bench for the 1-to-5 distributor.
module tb_demux1to5_dist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_data = '0;
    logic [2:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [59:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready = '0;
    logic [7:0]  misroute_cnt;
    logic        misroute_pulse;

    int n_cmp = 0;
    int n_err = 0;

    demux1to5_dist dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_sel         (in_sel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .misroute_cnt   (misroute_cnt),
        .misroute_pulse (misroute_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] slot(input int k);
        return out_data[k*12 +: 12];
    endfunction

    logic [11:0] route_words [5];
    logic [11:0] mis_words [3];

    initial begin
        route_words = '{12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4, 12'h0E5};
        mis_words   = '{12'h111, 12'h222, 12'h333};

        // Reset / idle
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_cnt", 64'(misroute_cnt), 64'h0);
        check("rst_pulse", 64'(misroute_pulse), 64'h0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 64'(out_valid), 64'h0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            check($sformatf("idle_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end

        // Basic routing, one word per channel on consecutive cycles
        out_ready = 5'b11111;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = route_words[i];
            #1;
            check($sformatf("route_ready%0d", i), 64'(in_ready), 64'h1);
            tick();
            check($sformatf("route_valid%0d", i), 64'(out_valid), 64'(5'b1 << i));
            check($sformatf("route_data%0d", i), 64'(slot(i)), 64'(route_words[i]));
        end
        in_valid = 1'b0;
        tick();
        check("route_drained", 64'(out_valid), 64'h0);

        // Backpressure on channel 2
        out_ready = 5'b11011;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 12'h123;
        tick();
        check("bp_valid_a", 64'(out_valid), 64'h04);
        check("bp_data_a", 64'(slot(2)), 64'h123);
        in_data = 12'h456;
        #1;
        check("bp_ready_low", 64'(in_ready), 64'h0);
        tick();
        check("bp_hold_data", 64'(slot(2)), 64'h123);
        check("bp_hold_valid", 64'(out_valid), 64'h04);
        in_sel  = 3'd3;
        in_data = 12'h789;
        #1;
        check("bp_other_ready", 64'(in_ready), 64'h1);
        tick();
        check("bp_other_valid", 64'(out_valid), 64'h0C);
        check("bp_other_data", 64'(slot(3)), 64'h789);
        check("bp_hold_data2", 64'(slot(2)), 64'h123);
        in_sel  = 3'd2;
        in_data = 12'h456;
        #1;
        check("bp_ready_low2", 64'(in_ready), 64'h0);
        tick();
        check("bp_stall_valid", 64'(out_valid), 64'h04);
        check("bp_stall_data", 64'(slot(2)), 64'h123);
        out_ready = 5'b11111;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'h1);
        tick();
        check("bp_replace_data", 64'(slot(2)), 64'h456);
        check("bp_replace_valid", 64'(out_valid), 64'h04);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(out_valid), 64'h0);
        check("bp_data_kept", 64'(slot(2)), 64'h456);

        // Misroutes land on channel 0 and are counted
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(5 + i);
            in_data  = mis_words[i];
            tick();
            check($sformatf("mis_data%0d", i), 64'(slot(0)), 64'(mis_words[i]));
            check($sformatf("mis_valid%0d", i), 64'(out_valid), 64'h01);
            check($sformatf("mis_pulse%0d", i), 64'(misroute_pulse), 64'h1);
            check($sformatf("mis_cnt%0d", i), 64'(misroute_cnt), 64'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("mis_pulse_off", 64'(misroute_pulse), 64'h0);
        check("mis_cnt3", 64'(misroute_cnt), 64'd3);
        in_valid = 1'b1;
        in_sel   = 3'd5;
        in_data  = 12'h0FF;
        for (int i = 0; i < 252; i++) tick();
        in_valid = 1'b0;
        tick();
        check("mis_cnt255", 64'(misroute_cnt), 64'd255);
        in_valid = 1'b1;
        in_sel   = 3'd7;
        tick();
        check("mis_sat_cnt", 64'(misroute_cnt), 64'd255);
        check("mis_sat_pulse", 64'(misroute_pulse), 64'h1);
        in_valid = 1'b0;
        tick();

        // Back-to-back stream on channel 4 with simultaneous drain
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'd4;
            in_data  = 12'(i);
            #1;
            check($sformatf("stream_ready%0d", i), 64'(in_ready), 64'h1);
            tick();
            check($sformatf("stream_valid%0d", i), 64'(out_valid[4]), 64'h1);
            check($sformatf("stream_data%0d", i), 64'(slot(4)), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 64'(out_valid), 64'h0);

        // Fill every channel, then reset asynchronously mid-operation
        out_ready = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = 12'hA00 + 12'(i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 64'(out_valid), 64'h1F);
        check("fill_data4", 64'(slot(4)), 64'hA04);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_data", 64'(out_data), 64'h0);
        check("async_rst_cnt", 64'(misroute_cnt), 64'h0);
        #1;
        rst_n = 1'b1;
        out_ready = 5'b11111;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h0);
        check("post_rst_data", 64'(out_data), 64'h0);
        tick();
        check("post_rst_valid2", 64'(out_valid), 64'h0);
        check("post_rst_pulse", 64'(misroute_pulse), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
